dm_present_hash_ctrl: RTL and testbench

DM_PRESENT_HASH_CTRL -- requirements
Module: dm_present_hash_ctrl

---
 rtl/dm_present_hash_ctrl.sv | 151 +++++++++++++++
 tb/tb_dm_present_hash_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_present_hash_ctrl.sv
// dm_present_hash_ctrl
// Davies-Meyer chaining controller around an external PRESENT-80 compression
// core. Each 80-bit message block is used as the core key, the chaining value
// H is the core plaintext, and the core returns H ^ E_K(H) as the new H. The
// digest is presented after the block flagged msg_last.
//
// Ports
//   clk, iReset_n              clock, synchronous active-low reset
//   msg_valid/msg_ready        message block handshake (msg_data, msg_last)
//   hash_valid/hash_ready      digest handshake (hash_out)
//   core_load                  one-cycle start pulse to the core
//   core_idat, core_key        chaining value and key to the core
//   core_odat, core_done       core result and completion pulse
//   busy, err, blk_cnt         status: not idle, sticky timeout, blocks absorbed
//
// state  | meaning
// IDLE   | ready for a message block
// LOAD   | start pulse to the core, wait counter cleared
// WAIT   | waiting for core_done or the timeout limit
// RESP   | digest offered until hash_ready
module dm_present_hash_ctrl #(
    parameter logic [63:0] IV      = 64'h0,
    parameter int          TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        iReset_n,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [79:0] msg_data,
    input  logic        msg_last,
    output logic        hash_valid,
    input  logic        hash_ready,
    output logic [63:0] hash_out,
    output logic        core_load,
    output logic [63:0] core_idat,
    output logic [79:0] core_key,
    input  logic [63:0] core_odat,
    input  logic        core_done,
    output logic        busy,
    output logic        err,
    output logic [15:0] blk_cnt
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [63:0]     h_reg;
    logic [79:0]     kreg;
    logic            lreg;
    logic [CW-1:0]   wait_cnt;
    logic            done_hit;
    logic            tmo_hit;

    // Completion wins over the timeout when both land on the same cycle.
    assign done_hit = (state == S_WAIT) && core_done;
    assign tmo_hit  = (state == S_WAIT) && !core_done && (wait_cnt == CW'(TIMEOUT - 1));

    // Core inputs are only driven while a block is in flight, so they read
    // zero out of reset regardless of IV.
    assign core_idat = (state == S_LOAD || state == S_WAIT) ? h_reg : 64'h0;
    assign core_key  = (state == S_LOAD || state == S_WAIT) ? kreg  : 80'h0;

    always_comb begin
        state_nxt  = state;
        msg_ready  = 1'b0;
        core_load  = 1'b0;
        hash_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                msg_ready = 1'b1;
                if (msg_valid)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                core_load = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done_hit)
                    state_nxt = lreg ? S_RESP : S_IDLE;
                else if (tmo_hit)
                    state_nxt = S_IDLE;
            end
            S_RESP: begin
                hash_valid = 1'b1;
                if (hash_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            state    <= S_IDLE;
            h_reg    <= IV;
            kreg     <= 80'h0;
            lreg     <= 1'b0;
            wait_cnt <= '0;
            blk_cnt  <= 16'h0;
            err      <= 1'b0;
            hash_out <= 64'h0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (msg_valid) begin
                        kreg <= msg_data;
                        lreg <= msg_last;
                    end
                end
                S_LOAD: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (done_hit) begin
                        h_reg <= core_odat;
                        if (blk_cnt != 16'hFFFF)
                            blk_cnt <= blk_cnt + 16'd1;
                        if (lreg)
                            hash_out <= core_odat;
                    end else if (tmo_hit) begin
                        err     <= 1'b1;
                        h_reg   <= IV;
                        blk_cnt <= 16'h0;
                    end
                end
                S_RESP: begin
                    // Next message starts a fresh chain from IV.
                    if (hash_ready) begin
                        h_reg   <= IV;
                        blk_cnt <= 16'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_present_hash_ctrl.sv
// Self-checking bench for dm_present_hash_ctrl: a behavioural core model
// (PRESENT-80 Davies-Meyer, a simple xor core, or a core that never finishes)
// and a message-level reference that folds blocks into a digest from IV.
module tb_dm_present_hash_ctrl;

    localparam logic [63:0] IV_TB = 64'h0;
    localparam int          TMO   = 48;

    logic        clk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [79:0] msg_data = 80'h0;
    logic        msg_last = 1'b0;
    logic        hash_valid;
    logic        hash_ready = 1'b0;
    logic [63:0] hash_out;
    logic        core_load;
    logic [63:0] core_idat;
    logic [79:0] core_key;
    logic [63:0] core_odat = 64'h0;
    logic        core_done = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] blk_cnt;

    int total = 0;
    int bad   = 0;

    dm_present_hash_ctrl #(.IV(IV_TB), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .iReset_n   (iReset_n),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_data   (msg_data),
        .msg_last   (msg_last),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash_out   (hash_out),
        .core_load  (core_load),
        .core_idat  (core_idat),
        .core_key   (core_key),
        .core_odat  (core_odat),
        .core_done  (core_done),
        .busy       (busy),
        .err        (err),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] sbox;
        logic [63:0] s;
        logic [63:0] t;
        logic [63:0] p;
        logic [79:0] k;
        sbox = 64'h21748FE3DA09B65C;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++)
                t[4*n +: 4] = sbox[4*int'(s[4*n +: 4]) +: 4];
            for (int b = 0; b < 63; b++)
                p[(16*b) % 63] = t[b];
            p[63] = t[63];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox[4*int'(k[79:76]) +: 4];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // mode 0: Davies-Meyer PRESENT, mode 1: xor 0x1111
    function automatic logic [63:0] compress(input int mode, input logic [63:0] h, input logic [79:0] k);
        if (mode == 0)
            return h ^ present80(h, k);
        return h ^ 64'h1111;
    endfunction

    // Core model: done appears core_lat cycles after the load pulse; mode 2 never completes.
    int          core_lat  = 4;
    int          core_mode = 0;
    int          c_left    = 0;
    bit          c_pend    = 1'b0;
    int          c_mode    = 0;
    logic [63:0] c_idat    = 64'h0;
    logic [79:0] c_key     = 80'h0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_load) begin
            c_pend = 1'b1;
            c_left = core_lat;
            c_mode = core_mode;
            c_idat = core_idat;
            c_key  = core_key;
        end else if (c_pend) begin
            c_left--;
            if (c_left <= 0) begin
                c_pend = 1'b0;
                if (c_mode != 2) begin
                    core_done = 1'b1;
                    core_odat = compress(c_mode, c_idat, c_key);
                end
            end
        end
    end

    function automatic logic [79:0] rnd_key();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    // Offers one block, then checks the load cycle and the first wait cycle.
    task automatic send_block(input logic [79:0] key, input logic last, input logic [63:0] exp_idat);
        int n;
        n = 0;
        @(negedge clk);
        while (!msg_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("msg_ready_wait", 80'(msg_ready), 80'(1));
        msg_valid = 1'b1;
        msg_data  = key;
        msg_last  = last;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_data  = rnd_key();
        chk("core_load", 80'(core_load), 80'(1));
        chk("core_key", core_key, key);
        chk("core_idat", 80'(core_idat), 80'(exp_idat));
        chk("load_busy_rdy", 80'({busy, msg_ready}), 80'(2'b10));
        @(negedge clk);
        chk("load_pulse_end", 80'(core_load), 80'(0));
        chk("idat_hold", 80'(core_idat), 80'(exp_idat));
        chk("key_hold", core_key, key);
    endtask

    task automatic wait_hash();
        int n;
        n = 0;
        while (!hash_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("hash_valid_wait", 80'(hash_valid), 80'(1));
    endtask

    task automatic accept_hash();
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
    endtask

    task automatic run_msg(input int nblk, input int mode, input int lat, input int hold,
                           input bit zero_keys, output logic [63:0] digest);
        logic [63:0] h;
        logic [79:0] k;
        h = IV_TB;
        core_mode = mode;
        core_lat  = lat;
        for (int b = 0; b < nblk; b++) begin
            k = zero_keys ? 80'h0 : rnd_key();
            send_block(k, (b == nblk - 1), h);
            h = compress(mode, h, k);
        end
        wait_hash();
        chk("digest", 80'(hash_out), 80'(h));
        chk("blk_cnt_resp", 80'(blk_cnt), 80'(nblk));
        repeat (hold) @(negedge clk);
        chk("hold_valid", 80'(hash_valid), 80'(1));
        chk("hold_digest", 80'(hash_out), 80'(h));
        accept_hash();
        chk("post_accept", 80'({busy, msg_ready, hash_valid}), 80'(3'b010));
        chk("post_blk_cnt", 80'(blk_cnt), 80'(0));
        chk("post_hash_out", 80'(hash_out), 80'(h));
        digest = h;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dg;
        logic [63:0] ho;
        logic [79:0] k;
        bit          stable;
        bit          seen_load;
        bit          seen_valid;
        bit          seen_busy;
        int          n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 80'({hash_valid, core_load, busy, err}), 80'(0));
        iReset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 80'(msg_ready), 80'(1));
        chk("rst_hash_out", 80'(hash_out), 80'(0));
        chk("rst_core_idat", 80'(core_idat), 80'(0));
        chk("rst_core_key", core_key, 80'(0));
        chk("rst_blk_cnt", 80'(blk_cnt), 80'(0));

        // single zero block through the real cipher
        run_msg(1, 0, 5, 5, 1'b1, dg);
        chk("present_vector", 80'(hash_out), 80'(64'h5579C1387B228445));

        // two blocks, xor core, 32-cycle latency
        run_msg(2, 1, 32, 0, 1'b0, dg);
        chk("two_blk_digest", 80'(hash_out), 80'(64'h0));

        // backpressure in RESP with a stray block offered
        core_mode = 0;
        core_lat  = 7;
        k = rnd_key();
        send_block(k, 1'b1, IV_TB);
        wait_hash();
        ho = hash_out;
        chk("bp_digest", 80'(ho), 80'(compress(0, IV_TB, k)));
        msg_valid = 1'b1;
        msg_data  = rnd_key();
        msg_last  = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hash_out !== ho || msg_ready !== 1'b0 || hash_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", 80'(stable), 80'(1));
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        msg_valid  = 1'b0;
        chk("bp_idle", 80'({busy, msg_ready, hash_valid}), 80'(3'b010));
        chk("bp_blk_cnt", 80'(blk_cnt), 80'(0));
        chk("bp_hash_hold", 80'(hash_out), 80'(ho));

        // done exactly at the timeout limit
        run_msg(1, 0, TMO, 0, 1'b0, dg);
        chk("edge_err", 80'(err), 80'(0));

        // timeout after one absorbed block, then chain restarts from IV
        core_mode = 1;
        core_lat  = 3;
        send_block(rnd_key(), 1'b0, IV_TB);
        core_mode = 2;
        send_block(rnd_key(), 1'b0, IV_TB ^ 64'h1111);
        n = 0;
        while (!err && n < TMO + 10) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 80'(n), 80'(TMO));
        chk("tmo_err", 80'(err), 80'(1));
        chk("tmo_idle", 80'({busy, msg_ready}), 80'(2'b01));
        chk("tmo_blk_cnt", 80'(blk_cnt), 80'(0));
        run_msg(1, 0, 4, 1, 1'b0, dg);
        chk("err_sticky", 80'(err), 80'(1));

        // reset in WAIT; the late core_done must be ignored
        core_mode = 0;
        core_lat  = 10;
        send_block(rnd_key(), 1'b1, IV_TB);
        repeat (2) @(negedge clk);
        iReset_n = 1'b0;
        @(negedge clk);
        iReset_n = 1'b1;
        seen_load = 1'b0;
        seen_valid = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_load  |= core_load;
            seen_valid |= hash_valid;
            seen_busy  |= busy;
        end
        chk("rstw_no_load", 80'(seen_load), 80'(0));
        chk("rstw_no_valid", 80'(seen_valid), 80'(0));
        chk("rstw_idle", 80'(seen_busy), 80'(0));
        chk("rstw_err_clr", 80'(err), 80'(0));
        chk("rstw_idat", 80'(core_idat), 80'(0));
        run_msg(1, 0, 6, 0, 1'b0, dg);

        // randomized messages
        for (int m = 0; m < 12; m++) begin
            run_msg(int'($urandom_range(1, 4)), int'($urandom_range(0, 1)),
                    int'($urandom_range(1, 20)), int'($urandom_range(0, 6)), 1'b0, dg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
